// File: rtl/tac_pkg.sv
// Shared state encoding, default widths and small helpers for the TAC interval channel.
package tac_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 1000;
  localparam int unsigned HOLDOFF_DEF = 4;
  localparam int unsigned MISS_W_DEF  = 8;
  localparam int unsigned STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DEAD    = 3'd4
  } tac_state_e;

  // Channel is busy whenever a start would not be accepted as a new measurement.
  function automatic logic is_busy(input tac_state_e st);
    return (st == ST_MEASURE) || (st == ST_HOLD) || (st == ST_DEAD);
  endfunction

  // Holdoff counter width, kept at least one bit for HOLDOFF_CYC of 0 or 1.
  function automatic int unsigned hold_width(input int unsigned holdoff);
    return (holdoff < 2) ? 1 : $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/tac_edge_pulse.sv
// Rising-edge detector for an already-synchronous discriminator line.
module tac_edge_pulse (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic pulse_out
);

  logic [1:0] sh_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sh_q <= 2'b00;
    end else begin
      sh_q <= {sh_q[0], sig_in};
    end
  end

  // Pure decode of the two history flops, so no input-to-output path.
  assign pulse_out = sh_q[0] & ~sh_q[1];

endmodule

// File: rtl/tac_interval_ctrl.sv
// One TAC timing channel: start->stop interval measurement with timeout, holdoff and lost-start count.
module tac_interval_ctrl
  import tac_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int unsigned HOLDOFF_CYC = HOLDOFF_DEF,
  parameter int unsigned MISS_W      = MISS_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic              start_in,
  input  logic              stop_in,
  output logic [CNT_W-1:0]  res_data_out,
  output logic              res_ovf_out,
  output logic              res_valid_out,
  input  logic              res_ack_in,
  output logic              busy_out,
  output logic [MISS_W-1:0] miss_cnt_out
);

  localparam int unsigned HOLD_W = hold_width(HOLDOFF_CYC);

  logic start_p;
  logic stop_p;

  tac_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  data_d;
  logic              ovf_d;
  logic              valid_d;
  logic              busy_d;
  logic [MISS_W-1:0] miss_d;
  logic              miss_ev;

  tac_edge_pulse u_start_edge (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .sig_in    (start_in),
    .pulse_out (start_p)
  );

  tac_edge_pulse u_stop_edge (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .sig_in    (stop_in),
    .pulse_out (stop_p)
  );

  // State and every output register update on the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      res_data_out  <= '0;
      res_ovf_out   <= 1'b0;
      res_valid_out <= 1'b0;
      busy_out      <= 1'b0;
      miss_cnt_out  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      res_data_out  <= data_d;
      res_ovf_out   <= ovf_d;
      res_valid_out <= valid_d;
      busy_out      <= busy_d;
      miss_cnt_out  <= miss_d;
    end
  end

  // Next-state, counters and result latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    data_d  = res_data_out;
    ovf_d   = res_ovf_out;
    valid_d = res_valid_out;

    case (state_q)
      ST_IDLE: begin
        if (en_in) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!en_in) begin
          state_d = ST_IDLE;
        end else if (start_p) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Abort beats stop, stop beats timeout.
        if (!en_in) begin
          state_d = ST_IDLE;
        end else if (stop_p) begin
          data_d  = cnt_q;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          data_d  = CNT_W'(TIMEOUT_CYC);
          ovf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ack_in) begin
          valid_d = 1'b0;
          if (HOLDOFF_CYC == 0) begin
            state_d = en_in ? ST_ARMED : ST_IDLE;
          end else begin
            state_d = ST_DEAD;
            hold_d  = HOLD_W'(HOLDOFF_CYC);
          end
        end
      end
      ST_DEAD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) state_d = en_in ? ST_ARMED : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lost starts: any start edge that cannot open a measurement while enabled.
  always_comb begin
    miss_ev = 1'b0;
    if (start_p) begin
      miss_ev = ((state_q == ST_IDLE) && en_in) || is_busy(state_q);
    end
    miss_d = miss_cnt_out;
    if (miss_ev && (miss_cnt_out != {MISS_W{1'b1}})) miss_d = miss_cnt_out + MISS_W'(1);
  end

  always_comb begin
    busy_d = is_busy(state_d);
  end

endmodule

// File: tb/tb_tac_interval_ctrl.sv
// Directed bench for tac_interval_ctrl; a second instance with zero holdoff covers back-to-back results.
module tb_tac_interval_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        en_in = 1'b0;
  logic        start_in = 1'b0;
  logic        stop_in = 1'b0;
  logic        res_ack_in = 1'b0;

  logic [15:0] res_data, res_data0;
  logic        res_ovf, res_ovf0;
  logic        res_valid, res_valid0;
  logic        busy, busy0;
  logic [7:0]  miss_cnt, miss_cnt0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  tac_interval_ctrl #(
    .CNT_W(16), .TIMEOUT_CYC(1000), .HOLDOFF_CYC(4), .MISS_W(8)
  ) u_dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .en_in         (en_in),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .res_data_out  (res_data),
    .res_ovf_out   (res_ovf),
    .res_valid_out (res_valid),
    .res_ack_in    (res_ack_in),
    .busy_out      (busy),
    .miss_cnt_out  (miss_cnt)
  );

  tac_interval_ctrl #(
    .CNT_W(16), .TIMEOUT_CYC(1000), .HOLDOFF_CYC(0), .MISS_W(8)
  ) u_dut0 (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .en_in         (en_in),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .res_data_out  (res_data0),
    .res_ovf_out   (res_ovf0),
    .res_valid_out (res_valid0),
    .res_ack_in    (res_ack_in),
    .busy_out      (busy0),
    .miss_cnt_out  (miss_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    bit seen;

    // Reset state
    rst_in = 1'b1;
    tick(2);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_ovf", 32'(res_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    rst_in = 1'b0;

    // Basic interval of 25 cycles, then 4 dead cycles
    en_in = 1'b1;
    tick(2);
    chk("t1_armed_busy", 32'(busy), 32'd0);
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(24);
    chk("t1_measure_busy", 32'(busy), 32'd1);
    stop_in = 1'b1;
    tick(1);
    stop_in = 1'b0;
    chk("t1_valid_early", 32'(res_valid), 32'd0);
    tick(1);
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_data", 32'(res_data), 32'd25);
    chk("t1_ovf", 32'(res_ovf), 32'd0);
    res_ack_in = 1'b1;
    tick(1);
    res_ack_in = 1'b0;
    chk("t1_valid_drop", 32'(res_valid), 32'd0);
    chk("t1_dead_busy", 32'(busy), 32'd1);
    tick(3);
    chk("t1_dead_busy3", 32'(busy), 32'd1);
    tick(1);
    chk("t1_rearm_busy", 32'(busy), 32'd0);

    // Timeout, stop ignored in HOLD, three lost starts
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(1000);
    chk("t2_valid_early", 32'(res_valid), 32'd0);
    tick(1);
    chk("t2_valid", 32'(res_valid), 32'd1);
    chk("t2_data", 32'(res_data), 32'd1000);
    chk("t2_ovf", 32'(res_ovf), 32'd1);
    stop_in = 1'b1;
    tick(2);
    stop_in = 1'b0;
    tick(1);
    chk("t2_hold_valid", 32'(res_valid), 32'd1);
    chk("t2_hold_data", 32'(res_data), 32'd1000);
    chk("t2_hold_ovf", 32'(res_ovf), 32'd1);
    for (int i = 0; i < 3; i++) begin
      start_in = 1'b1;
      tick(1);
      start_in = 1'b0;
      tick(1);
    end
    tick(1);
    chk("t2_miss3", 32'(miss_cnt), 32'd3);
    res_ack_in = 1'b1;
    tick(1);
    res_ack_in = 1'b0;
    tick(5);
    chk("t2_rearm_busy", 32'(busy), 32'd0);

    // Start and stop together; the next stop 10 cycles later ends it
    start_in = 1'b1;
    stop_in  = 1'b1;
    tick(1);
    start_in = 1'b0;
    stop_in  = 1'b0;
    tick(9);
    chk("t3_no_early", 32'(res_valid), 32'd0);
    stop_in = 1'b1;
    tick(1);
    stop_in = 1'b0;
    tick(1);
    chk("t3_valid", 32'(res_valid), 32'd1);
    chk("t3_data", 32'(res_data), 32'd10);
    chk("t3_ovf", 32'(res_ovf), 32'd0);
    res_ack_in = 1'b1;
    tick(1);
    res_ack_in = 1'b0;
    tick(5);

    // Abort mid-measure; stop while idle does nothing
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(5);
    chk("t4_measuring", 32'(busy), 32'd1);
    en_in = 1'b0;
    tick(1);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    stop_in = 1'b1;
    tick(3);
    stop_in = 1'b0;
    tick(2);
    chk("t4_no_valid", 32'(res_valid), 32'd0);
    chk("t4_miss_kept", 32'(miss_cnt), 32'd3);

    // Miss counter saturation, then reset while in HOLD
    en_in = 1'b1;
    tick(2);
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    tick(1);
    for (int i = 0; i < 300; i++) begin
      start_in = 1'b1;
      tick(1);
      start_in = 1'b0;
      tick(1);
    end
    tick(1);
    chk("t5_miss_sat", 32'(miss_cnt), 32'd255);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (res_valid) seen = 1'b1;
      else tick(1);
    end
    chk("t5_valid_seen", 32'(seen), 32'd1);
    chk("t5_timeout_ovf", 32'(res_ovf), 32'd1);
    rst_in = 1'b1;
    tick(1);
    chk("t5_rst_valid", 32'(res_valid), 32'd0);
    chk("t5_rst_miss", 32'(miss_cnt), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_data", 32'(res_data), 32'd0);
    rst_in = 1'b0;

    // Zero-holdoff instance: ack held high, 10 back-to-back measurements
    res_ack_in = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      start_in = 1'b1;
      tick(1);
      start_in = 1'b0;
      tick(i);
      stop_in = 1'b1;
      tick(1);
      stop_in = 1'b0;
      chk($sformatf("t6_pre_%0d", i), 32'(res_valid0), 32'd0);
      tick(1);
      chk($sformatf("t6_valid_%0d", i), 32'(res_valid0), 32'd1);
      chk($sformatf("t6_data_%0d", i), 32'(res_data0), 32'(i + 1));
      tick(1);
      chk($sformatf("t6_drop_%0d", i), 32'(res_valid0), 32'd0);
      chk($sformatf("t6_armed_%0d", i), 32'(busy0), 32'd0);
    end
    res_ack_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
